md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle controller for the shared multiply/divide resource behind HI/LO. It sits
//  in EX and accepts one MULT/MULTU/DIV/DIVU per start.
//  While busy it raises a stall request so the pipeline holds the instruction in EX.
//  On completion it emits a 66-bit hilo bus {hi_we,hi,lo_we,lo} (same packing as the
//  EX->ID hilo forward), which EX merges into its forward/writeback bus.
// PARAMETERS
//  DIV_ITERS  32  restoring-division iterations; must equal operand width
//  DATA_WD    32  operand/result width
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous active-high reset
//  start      in   1   EX holds a valid md op (level; held while stalled)
//  cancel     in   1   flush/abort of the EX instruction; synchronous
//  md_op      in   4   one-hot {mult,multu,div,divu}
//  src_a      in   32  rs value (dividend / multiplicand)
//  src_b      in   32  rt value (divisor / multiplier)
//  stallreq   out  1   hold pipeline; to stall controller
//  done       out  1   one-cycle pulse; hilo_bus valid this cycle
//  hilo_bus   out  66  {hi_we,hi[31:0],lo_we,lo[31:0]}; we bits = done
// BEHAVIOUR
//  - Reset: state=IDLE, stallreq=0, done=0, hilo_bus=0, cnt=0, operand regs=0.
//  - States: IDLE, MUL, DIV, FIX, DONE (encodings live in the shared header).
//  - IDLE: start&~cancel -> latch op/operands. Mult -> MUL. Div -> DIV with cnt=0,
//    using |src_a| and |src_b| for signed ops and remembering both signs.
//  - MUL: registered 64-bit product, signed or unsigned -> DONE. done at T+2.
//  - DIV: one shift-subtract step per cycle; cnt==DIV_ITERS-1 -> FIX.
//  - FIX: quotient negated if signs differ; remainder takes dividend sign -> DONE.
//    Div latency: start accepted at T, done at T+34.
//  - Divide by zero, signed or unsigned: architectural result hi=src_a (original),
//    lo=32'hFFFF_FFFF; FIX forces this.
//  - DONE: done=1, hi/lo valid, stallreq=0, pipeline advances -> IDLE.
//    start seen in DONE is ignored. A new op may start on the following cycle.
//  - stallreq = (IDLE & start & ~cancel) | MUL | DIV | FIX. It is combinational, so the
//    accept cycle is already stalled.
//  - cancel in any non-IDLE state -> IDLE next cycle, no done, stallreq drops that
//    cycle. cancel beats start in IDLE.
//  - rst mid-operation aborts like cancel and also clears all registers.
//  - Results: mult hi=prod[63:32], lo=prod[31:0]; div hi=remainder, lo=quotient.
//  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0, no trap.
// CONFIGURATION
//  MD_DIV_ZERO_EARLY_EN defined:
//   - a div with src_b==0 goes IDLE -> DONE directly; done at T+1.
//   - Result values are identical to the full-length path.
//  Undefined: div-by-zero runs the full DIV+FIX path, done at T+34.
// STRUCTURE
//  - Shared header (lib/defines.vh) holds:
//    - MD_OP_WD=4 and the one-hot op bit positions
//    - MD_HILO_WD=66
//    - state encodings MD_IDLE/MD_MUL/MD_DIV/MD_FIX/MD_DONE
//  - Sub-module md_div_iter: holds the remainder/quotient registers and one
//    restoring step per enable.
//  - The FSM, sign handling and the multiplier stay in md_sequencer.
// TESTING
//  - multu 0xFFFFFFFF*0xFFFFFFFF -> done at T+2, hi=0xFFFFFFFE, lo=0x00000001,
//    stallreq high T..T+1.
//  - div -7/2 -> done T+34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//    divu 100/7 -> lo=14, hi=2.
//  - divu 5/0 -> hi=5, lo=0xFFFFFFFF. Done at T+34 without the macro, at T+1 with
//    MD_DIV_ZERO_EARLY_EN.
//  - div start, cancel at T+10 -> IDLE at T+11, no done pulse. Then mult 3*-4 at T+12 ->
//    done T+14, hi=0xFFFFFFFF, lo=0xFFFFFFF4.
//  - rst at T+5 of a div -> all outputs 0 next cycle; start+cancel in IDLE -> no accept,
//    stallreq=0.
//  - div 0x80000000/-1 -> lo=0x80000000, hi=0. Back-to-back mult right after DONE is
//    accepted.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer.
//   - op vector width and one-hot bit positions of md_op
//   - width of the packed hilo bus {hi_we, hi, lo_we, lo}
//   - FSM state encodings
// Configuration macro honoured by md_sequencer: MD_DIV_ZERO_EARLY_EN.
package md_sequencer_pkg;

  localparam int MD_OP_WD   = 4;
  localparam int MD_HILO_WD = 66;

  // One-hot positions inside md_op = {mult, multu, div, divu}
  localparam int MD_OP_MULT  = 3;
  localparam int MD_OP_MULTU = 2;
  localparam int MD_OP_DIV   = 1;
  localparam int MD_OP_DIVU  = 0;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/md_div_iter.sv
// Restoring-division datapath: remainder, quotient and divisor registers
// plus one shift-subtract step per enabled cycle. Works on magnitudes only;
// sign correction is done by the caller.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_i          capture dividend/divisor, clear remainder
//   step_i          perform one restoring step
//   dividend_i      unsigned dividend
//   divisor_i       unsigned divisor
//   rem_o, quo_o    current remainder / quotient
module md_div_iter #(
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [DATA_WD-1:0] dividend_i,
  input  logic [DATA_WD-1:0] divisor_i,
  output logic [DATA_WD-1:0] rem_o,
  output logic [DATA_WD-1:0] quo_o
);

  logic [DATA_WD-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_WD:0]   shifted, trial;

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; bit DATA_WD of the difference is the borrow.
  assign shifted = {rem_q, quo_q[DATA_WD-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      if (!trial[DATA_WD]) begin
        rem_q <= trial[DATA_WD-1:0];
        quo_q <= {quo_q[DATA_WD-2:0], 1'b1};
      end else begin
        rem_q <= shifted[DATA_WD-1:0];
        quo_q <= {quo_q[DATA_WD-2:0], 1'b0};
      end
    end
  end

  assign rem_o = rem_q;
  assign quo_o = quo_q;

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle controller for the shared multiply/divide unit behind HI/LO.
// Accepts one MULT/MULTU/DIV/DIVU per start, stalls the pipeline while busy
// and emits a one-cycle hilo bus {hi_we, hi, lo_we, lo} on completion.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        EX holds a valid md op (level, held while stalled)
//   cancel       flush of the EX instruction; aborts any operation
//   md_op        one-hot {mult, multu, div, divu}
//   src_a/src_b  rs / rt operands
//   stallreq     hold the pipeline (combinational, high in the accept cycle)
//   done         one-cycle completion pulse
//   hilo_bus     {hi_we, hi, lo_we, lo}, we bits equal done
// Configuration: define MD_DIV_ZERO_EARLY_EN to finish divide-by-zero in one
// cycle instead of running the full iteration.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int DATA_WD   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cancel,
  input  logic [MD_OP_WD-1:0]  md_op,
  input  logic [DATA_WD-1:0]   src_a,
  input  logic [DATA_WD-1:0]   src_b,
  output logic                 stallreq,
  output logic                 done,
  output logic [2*DATA_WD+1:0] hilo_bus
);

  localparam int CNT_W = $clog2(DIV_ITERS);
`ifdef MD_DIV_ZERO_EARLY_EN
  localparam bit EarlyZero = 1'b1;
`else
  localparam bit EarlyZero = 1'b0;
`endif

  function automatic logic [DATA_WD-1:0] mag(input logic [DATA_WD-1:0] v,
                                             input logic is_signed);
    return (is_signed && v[DATA_WD-1]) ? -v : v;
  endfunction

  md_state_e          state_q, state_d;
  logic [DATA_WD-1:0] a_q, b_q, res_hi_q, res_lo_q, res_hi_d, res_lo_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               signed_q, res_we;
  logic               op_mul, op_div, op_signed, accept, div_load;
  logic [DATA_WD-1:0] rem, quo;
  logic [2*DATA_WD-1:0] mul_a, mul_b, prod;
  logic               sign_a, sign_b;

  assign op_mul    = md_op[MD_OP_MULT] | md_op[MD_OP_MULTU];
  assign op_div    = md_op[MD_OP_DIV]  | md_op[MD_OP_DIVU];
  assign op_signed = md_op[MD_OP_MULT] | md_op[MD_OP_DIV];
  // cancel beats start; a start without any op bit is never accepted
  assign accept    = (state_q == MD_IDLE) && start && !cancel && (op_mul || op_div);
  assign div_load  = accept && op_div;

  // Sign-extending both operands to full product width lets a single
  // unsigned multiplier produce the exact signed or unsigned 64-bit result.
  assign mul_a = signed_q ? {{DATA_WD{a_q[DATA_WD-1]}}, a_q} : {{DATA_WD{1'b0}}, a_q};
  assign mul_b = signed_q ? {{DATA_WD{b_q[DATA_WD-1]}}, b_q} : {{DATA_WD{1'b0}}, b_q};
  assign prod  = mul_a * mul_b;

  assign sign_a = signed_q & a_q[DATA_WD-1];
  assign sign_b = signed_q & b_q[DATA_WD-1];

  md_div_iter #(.DATA_WD(DATA_WD)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (state_q == MD_DIV),
    .dividend_i (mag(src_a, op_signed)),
    .divisor_i  (mag(src_b, op_signed)),
    .rem_o      (rem),
    .quo_o      (quo)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    res_we   = 1'b0;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          if (op_mul) begin
            state_d = MD_MUL;
          end else if (EarlyZero && src_b == '0) begin
            state_d  = MD_DONE;
            res_we   = 1'b1;
            res_hi_d = src_a;
            res_lo_d = '1;
          end else begin
            state_d = MD_DIV;
          end
        end
      end
      MD_MUL: begin
        state_d  = MD_DONE;
        res_we   = 1'b1;
        res_hi_d = prod[2*DATA_WD-1:DATA_WD];
        res_lo_d = prod[DATA_WD-1:0];
      end
      MD_DIV: begin
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_DONE;
        res_we  = 1'b1;
        if (b_q == '0) begin
          res_hi_d = a_q;
          res_lo_d = '1;
        end else begin
          res_hi_d = sign_a ? -rem : rem;
          res_lo_d = (sign_a ^ sign_b) ? -quo : quo;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (cancel && state_q != MD_IDLE) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= src_a;
        b_q      <= src_b;
        signed_q <= op_signed;
        cnt_q    <= '0;
      end
      if (state_q == MD_DIV) cnt_q <= cnt_q + 1'b1;
      if (res_we) begin
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
      end
    end
  end

  assign stallreq = accept ||
                    (!cancel && (state_q == MD_MUL || state_q == MD_DIV || state_q == MD_FIX));
  // A flush arriving in the completion cycle also suppresses the writeback.
  assign done     = (state_q == MD_DONE) && !cancel;
  assign hilo_bus = done ? {1'b1, res_hi_q, 1'b1, res_lo_q} : '0;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer. Stimulus pushes the expected hilo result
// and its due cycle into a scoreboard; a monitor pops and compares on every
// done pulse. Stall behaviour is checked cycle by cycle in the stimulus.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst, start, cancel;
  logic [MD_OP_WD-1:0]   md_op;
  logic [31:0]           src_a, src_b;
  logic                  stallreq, done;
  logic [MD_HILO_WD-1:0] hilo_bus;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0001;
`ifdef MD_DIV_ZERO_EARLY_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  md_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cancel   (cancel),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .done     (done),
    .hilo_bus (hilo_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 66'(done), 66'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hilo_bus", hilo_bus, {1'b1, e.hi, 1'b1, e.lo});
        check("done_cycle", 66'(cyc), 66'(e.due));
      end
    end
  end

  // Issue one op, hold start while stalled, drop it in the DONE cycle.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int t0;
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    t0 = cyc;
    sb.push_back('{hi: hi, lo: lo, due: t0 + lat});
    #1 check({name, "_stall_accept"}, 66'(stallreq), 66'(1));
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      #1 check({name, "_stall_busy"}, 66'(stallreq), 66'(1));
    end
    @(negedge clk);
    start = 1'b0;
    #1 check({name, "_stall_done"}, 66'(stallreq), 66'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stallreq", 66'(stallreq), 66'(0));
    check("reset_done", 66'(done), 66'(0));
    check("reset_hilo", hilo_bus, 66'(0));

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
    run_op("mult_m1m1", OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 2);
    run_op("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("div_7_m2",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34);
    run_op("div_m7_m2", OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 34);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op("divu_big_3", OP_DIVU, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 34);
    run_op("divu_5_0",  OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, ZERO_LAT);
    run_op("div_m9_0",  OP_DIV,   32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, ZERO_LAT);

    // Cancel a divide at T+10: no done pulse, idle at T+11, mult at T+12.
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    t0 = cyc;
    while (cyc < t0 + 10) @(negedge clk);
    cancel = 1'b1;
    #1 check("cancel_stall_drop", 66'(stallreq), 66'(0));
    check("cancel_no_done", 66'(done), 66'(0));
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    #1 check("cancel_idle", 66'(stallreq), 66'(0));
    run_op("mult_3_m4", OP_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 2);

    // Reset at T+5 of a divide.
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; src_a = 32'd50; src_b = 32'd5;
    t0 = cyc;
    while (cyc < t0 + 5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_stallreq", 66'(stallreq), 66'(0));
    check("rst_done", 66'(done), 66'(0));
    check("rst_hilo", hilo_bus, 66'(0));
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; md_op = OP_MULT; src_a = 32'd2; src_b = 32'd2;
    #1 check("start_cancel_stall", 66'(stallreq), 66'(0));
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1 check("start_cancel_no_accept", 66'(stallreq), 66'(0));

    // Signed overflow, then a mult accepted right after DONE.
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);
    run_op("mult_b2b", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2);

    repeat (5) @(negedge clk);
    #3 check("scoreboard_drained", 66'(sb.size()), 66'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
